// File: rtl/bitrev_spi_pkg.sv
// Shared types and constants for the bitrev SPI master: FSM states and
// the framing constants of one 8-bit-out / 8-bit-back exchange.
package bitrev_spi_pkg;

  localparam int BYTE_W        = 8;
  localparam int SHIFT_EDGES   = 32;
  localparam int RX_FIRST_FALL = 8;
  localparam int RX_LAST_FALL  = 15;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    RESP
  } state_t;

endpackage

// File: rtl/bitrev_spi_ctrl_clk_div.sv
// sck half-period divider: one tick every CLK_DIV enabled cycles; sck toggles
// on each tick while sck_en is high. Counter and sck clear when disabled.
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic sck_en,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic sck
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == DIV_W'(CLK_DIV - 1));
  assign rise = tick && sck_en && !sck;
  assign fall = tick && sck_en && sck;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
      if (!sck_en)
        sck <= 1'b0;
      else if (tick)
        sck <= !sck;
    end
  end

endmodule

// File: rtl/bitrev_spi_ctrl.sv
// SPI master framing one exchange with the bitrev slave: 8 bits out on mosi,
// then 8 bit-reversed bits back on miso, behind valid/ready byte ports.
module bitrev_spi_ctrl
  import bitrev_spi_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int SS_SETUP = 1,
  parameter int SS_HOLD  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [BYTE_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [BYTE_W-1:0] rsp_data,
  output logic              busy,
  output logic              spi_sck,
  output logic              spi_ss,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int PH_MAX = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  state_t            state, state_nxt;
  logic [PH_W-1:0]   ph_cnt;
  logic [4:0]        edge_cnt;
  logic [4:0]        fall_k;
  logic [BYTE_W-2:0] tx_sr;
  logic [BYTE_W-1:0] rx_sr;
  logic              div_en, sck_en, tick, rise, fall;
  logic              accept, setup_done, shift_done, hold_done;

  assign req_ready  = (state == IDLE) && !reset;
  assign busy       = (state != IDLE);
  assign accept     = req_valid && req_ready;
  assign div_en     = state inside {SETUP, SHIFT, HOLD};
  assign sck_en     = (state == SHIFT);
  assign setup_done = tick && (ph_cnt == PH_W'(SS_SETUP - 1));
  assign hold_done  = tick && (ph_cnt == PH_W'(SS_HOLD - 1));
  assign shift_done = fall && (edge_cnt == 5'(SHIFT_EDGES - 1));
  // Falling edges sit at odd edge counts 2k-1, so k = edge_cnt/2 + 1.
  assign fall_k     = 5'(edge_cnt[4:1]) + 5'd1;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clock  (clock),
    .reset  (reset),
    .en     (div_en),
    .sck_en (sck_en),
    .tick   (tick),
    .rise   (rise),
    .fall   (fall),
    .sck    (spi_sck)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: the default assignment up front keeps every path driven, so no
  // latch is inferred for state_nxt.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)     state_nxt = SETUP;
      SETUP:   if (setup_done) state_nxt = SHIFT;
      SHIFT:   if (shift_done) state_nxt = HOLD;
      HOLD:    if (hold_done)  state_nxt = RESP;
      RESP:    if (rsp_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ph_cnt    <= '0;
      edge_cnt  <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      spi_ss    <= 1'b0;
      spi_mosi  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          tx_sr    <= req_data[BYTE_W-2:0];
          rx_sr    <= '0;
          spi_ss   <= 1'b1;
          spi_mosi <= req_data[BYTE_W-1];
        end
        SETUP: if (tick) ph_cnt <= setup_done ? '0 : ph_cnt + PH_W'(1);
        SHIFT: begin
          if (rise || fall) edge_cnt <= shift_done ? '0 : edge_cnt + 5'd1;
          if (fall) begin
            if (fall_k < 5'(BYTE_W)) begin
              spi_mosi <= tx_sr[BYTE_W-2];
              tx_sr    <= {tx_sr[BYTE_W-3:0], 1'b0};
            end else begin
              spi_mosi <= 1'b0;
            end
            if (fall_k >= 5'(RX_FIRST_FALL) && fall_k <= 5'(RX_LAST_FALL))
              rx_sr <= {rx_sr[BYTE_W-2:0], spi_miso};
          end
        end
        HOLD: if (tick) begin
          if (hold_done) begin
            ph_cnt    <= '0;
            spi_ss    <= 1'b0;
            rsp_data  <= rx_sr;
            rsp_valid <= 1'b1;
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitrev_spi_ctrl.sv
// Directed bench for bitrev_spi_ctrl with behavioural bitrev slaves; one DUT
// at CLK_DIV=2 and one at CLK_DIV=1 share the clock.
module tb_bitrev_spi_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- DUT A: CLK_DIV = 2 ----------------
  logic       reset = 1'b1;
  logic       req_valid = 1'b0, rsp_ready = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, rsp_valid, busy, spi_sck, spi_ss, spi_mosi;
  logic [7:0] rsp_data;
  logic       spi_miso = 1'b0;

  bitrev_spi_ctrl #(.CLK_DIV(2), .SS_SETUP(1), .SS_HOLD(1)) u_dut (
    .clock(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .spi_sck(spi_sck), .spi_ss(spi_ss),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  // Slave A: restarts on ss rise, samples mosi on rising 1..8, then drives
  // d0..d7 on miso from rising 8 onwards.
  logic [7:0]  sl_sr = 8'h00;
  int          sl_cnt = 0;
  logic [15:0] mosi_bits = 16'h0;
  always @(posedge spi_ss or posedge spi_sck) begin
    if (!spi_sck) begin
      sl_cnt    = 0;
      mosi_bits = 16'h0;
    end else if (spi_ss) begin
      sl_cnt++;
      if (sl_cnt <= 16) mosi_bits[16-sl_cnt] = spi_mosi;
      if (sl_cnt <= 8) sl_sr = {sl_sr[6:0], spi_mosi};
      else             sl_sr = {1'b0, sl_sr[7:1]};
      if (sl_cnt >= 8) spi_miso = sl_sr[0];
    end
  end

  // ---------------- DUT B: CLK_DIV = 1 ----------------
  logic       reset_1 = 1'b1;
  logic       req_valid_1 = 1'b0, rsp_ready_1 = 1'b0;
  logic [7:0] req_data_1 = 8'h00;
  logic       req_ready_1, rsp_valid_1, busy_1, spi_sck_1, spi_ss_1, spi_mosi_1;
  logic [7:0] rsp_data_1;
  logic       spi_miso_1 = 1'b0;

  bitrev_spi_ctrl #(.CLK_DIV(1), .SS_SETUP(1), .SS_HOLD(1)) u_dut_1 (
    .clock(clk), .reset(reset_1),
    .req_valid(req_valid_1), .req_ready(req_ready_1), .req_data(req_data_1),
    .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1), .rsp_data(rsp_data_1),
    .busy(busy_1), .spi_sck(spi_sck_1), .spi_ss(spi_ss_1),
    .spi_mosi(spi_mosi_1), .spi_miso(spi_miso_1)
  );

  logic [7:0] sl_sr_1 = 8'h00;
  int         sl_cnt_1 = 0;
  always @(posedge spi_ss_1 or posedge spi_sck_1) begin
    if (!spi_sck_1) begin
      sl_cnt_1 = 0;
    end else if (spi_ss_1) begin
      sl_cnt_1++;
      if (sl_cnt_1 <= 8) sl_sr_1 = {sl_sr_1[6:0], spi_mosi_1};
      else               sl_sr_1 = {1'b0, sl_sr_1[7:1]};
      if (sl_cnt_1 >= 8) spi_miso_1 = sl_sr_1[0];
    end
  end

  // One exchange on DUT A: lat = cycles from handshake cycle to first rsp_valid.
  task automatic do_req(input logic [7:0] d, output logic [7:0] r, output int lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = d;
    rsp_ready = 1'b0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      req_valid = 1'b0;
      if (rsp_valid) break;
    end
    if (!rsp_valid) lat = -1;
    r = rsp_data;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [7:0] r;
  int         lat, gap, n_acc, n_rsp, tog;
  logic       pend, stable, prev;
  logic [7:0] rsp_q [2];

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data",  rsp_data,  8'h00);
    check("rst_busy",      busy,      1'b0);
    check("rst_sck",       spi_sck,   1'b0);
    check("rst_ss",        spi_ss,    1'b0);
    check("rst_mosi",      spi_mosi,  1'b0);
    reset = 1'b0;
    reset_1 = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1'b1);

    // 0x01 -> 0x80, latency and rising-edge count
    do_req(8'h01, r, lat);
    check("rsp_01",   r,      8'h80);
    check("lat_01",   lat,    69);
    check("rises_01", sl_cnt, 16);

    // 0xB4 -> 0x2D, mosi seen by slave at rising 1..16
    do_req(8'hB4, r, lat);
    check("rsp_b4",   r,         8'h2D);
    check("mosi_b4",  mosi_bits, 16'hB400);
    check("rises_b4", sl_cnt,    16);

    // Response stall: 0xC1 -> 0x83, held 20 cycles; a new request meanwhile is ignored
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = 8'hC1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      req_data = 8'h55;
      if (rsp_valid) break;
    end
    stable = rsp_valid;
    repeat (20) begin
      @(negedge clk);
      if (!(rsp_valid && rsp_data == 8'h83 && !req_ready && busy && !spi_sck && !spi_ss))
        stable = 1'b0;
    end
    check("stall_stable", stable,   1'b1);
    check("stall_data",   rsp_data, 8'h83);
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("stall_release_valid", rsp_valid, 1'b0);
    check("stall_release_ready", req_ready, 1'b1);
    @(negedge clk);
    check("rsp_ready_idle_ignored", {rsp_valid, busy}, 2'b00);
    rsp_ready = 1'b0;

    // Back-to-back 0x0F then 0xF0 with req_valid held
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = 8'h0F;
    rsp_ready = 1'b1;
    n_acc = 0; n_rsp = 0; gap = 0;
    rsp_q[0] = 8'h00; rsp_q[1] = 8'h00;
    pend = req_valid && req_ready;
    for (int i = 0; i < 400 && n_rsp < 2; i++) begin
      @(negedge clk);
      if (pend) begin
        n_acc++;
        if (n_acc == 1) req_data = 8'hF0;
        else            req_valid = 1'b0;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_q[n_rsp] = rsp_data;
        n_rsp++;
      end
      if (n_rsp >= 1 && n_acc < 2 && !spi_ss) gap++;
      pend = req_valid && req_ready;
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("b2b_rsp0", rsp_q[0], 8'hF0);
    check("b2b_rsp1", rsp_q[1], 8'h0F);
    check("b2b_ss_gap", gap >= 1, 1'b1);
    check("b2b_accepts", n_acc, 2);

    // CLK_DIV=1: 0xFF -> 0xFF, sck toggles every cycle of SHIFT
    @(negedge clk);
    req_valid_1 = 1'b1;
    req_data_1  = 8'hFF;
    rsp_ready_1 = 1'b0;
    lat = 0; tog = 0; prev = spi_sck_1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      req_valid_1 = 1'b0;
      if (spi_sck_1 != prev) tog++;
      prev = spi_sck_1;
      if (rsp_valid_1) break;
    end
    check("div1_rsp",     rsp_data_1, 8'hFF);
    check("div1_lat",     lat,        35);
    check("div1_toggles", tog,        32);
    rsp_ready_1 = 1'b1;
    @(negedge clk);
    rsp_ready_1 = 1'b0;

    // CLK_DIV=1: reset while sck is high mid-SHIFT
    @(negedge clk);
    req_valid_1 = 1'b1;
    req_data_1  = 8'hA5;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      req_valid_1 = 1'b0;
      if (spi_sck_1) break;
    end
    check("mid_pre_ss", {spi_ss_1, spi_sck_1}, 2'b11);
    #1 reset_1 = 1'b1;
    #1;
    check("mid_rst_sck",   spi_sck_1,   1'b0);
    check("mid_rst_ss",    spi_ss_1,    1'b0);
    check("mid_rst_mosi",  spi_mosi_1,  1'b0);
    check("mid_rst_busy",  busy_1,      1'b0);
    check("mid_rst_ready", req_ready_1, 1'b0);
    @(negedge clk);
    reset_1 = 1'b0;
    @(negedge clk);
    check("mid_rst_recover_ready", req_ready_1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
